fetch_bus_arbiter: RTL and testbench
====================================

Name: fetch_bus_arbiter

Overview:
- Two-requester TileLink-UL arbiter and sequencer that shares the single core-side memory port between the instruction cache (requester 0) and the data cache (requester 1).
- It allows one transaction in flight at a time. It locks the grant from A-channel issue until the matching D-channel response, and alternates priority round-robin.
- It guards against a hung slave with a response timeout that returns a denied response to the stalled requester.
- It sits between the fetch/LSU caches and the SoC crossbar.

Parameters:
- ADDR_W, 64, address width of A channel.
- DATA_W, 64, data width of A/D channels.
- TIMEOUT, 1024, cycles to wait for D response before forcing an error completion (min 2).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- m0_a_valid / m1_a_valid  input  1  requester A-channel request; held high until the requester sees its d_valid
- m0_a_opcode / m1_a_opcode  input  3  TL opcode (Get/PutFull)
- m0_a_size / m1_a_size  input  3  log2 bytes
- m0_a_address / m1_a_address  input  ADDR_W  request address
- m0_a_mask / m1_a_mask  input  DATA_W/8  byte mask
- m0_a_data / m1_a_data  input  DATA_W  write data
- m0_d_valid / m1_d_valid  output  1  response beat to requester
- m0_d_denied / m1_d_denied  output  1  response is an error (timeout or slave denied)
- m0_d_data / m1_d_data  output  DATA_W  response data
- s_a_valid  output  1  downstream request valid
- s_a_ready  input  1  downstream accepts A beat
- s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data  output  3/3/ADDR_W/DATA_W/8/DATA_W  registered copy of granted request
- s_a_source  output  4  {3'b0, grant index}
- s_d_valid  input  1  downstream response valid
- s_d_ready  output  1  constant 1
- s_d_source  input  4  response source ID
- s_d_denied  input  1  slave error
- s_d_data  input  DATA_W  response data
- grant  output  2  one-hot current owner, 2'b00 when idle
- busy  output  1  transaction in flight

Behaviour:
- Reset: state IDLE; all outputs 0 except s_d_ready=1; priority pointer favors requester 0; timeout counter 0.
- States:
  - IDLE: pick a requester.
    - Only one m*_a_valid → grant it.
    - Both → grant the requester indicated by the priority pointer, then flip the pointer to the other requester.
    - Grant taken: register the granted A fields plus source, set grant, go ISSUE. s_a_valid rises the next cycle (1-cycle latency).
  - ISSUE: hold s_a_valid and all A fields stable until s_a_valid & s_a_ready, then drop s_a_valid the same edge and go WAIT. The counter is cleared on entry.
  - WAIT: counter increments each cycle.
    - s_d_valid with s_d_source[0]==grant index: forward s_d_data/s_d_denied to the owner for exactly 1 cycle (registered, 1-cycle latency from s_d_valid), then go DONE.
    - Counter reaches TIMEOUT-1: pulse owner d_valid with d_denied=1 and d_data=0, then go DONE.
    - s_d_valid with mismatched source: ignored (dropped).
  - DONE: one bubble cycle so the requester can deassert a_valid; grant cleared; go IDLE. A requester re-requests no earlier than 2 cycles after its d_valid.
- m*_a_valid dropping while in ISSUE/WAIT is ignored; the transaction completes and the response is still delivered.
- Simultaneous s_d_valid and timeout in the same cycle: the real response wins (d_denied=s_d_denied).
- busy=1 in ISSUE, WAIT, DONE.
- Reset mid-transaction: immediate return to IDLE and all outputs zero; a late s_d_valid after reset arrives in IDLE and is ignored.
- Non-owner m*_d_valid is always 0.
- Pointer changes only when both requesters contend.

Test Plan:
- Single icache Get to 0x8000_0000, s_a_ready=1, s_d_valid 3 cycles later with data 0x1122334455667788 → s_a_source=0, grant=01; m0_d_valid pulses once with that data; m1 untouched.
- Both request in the same cycle from reset → requester 0 served first, then requester 1; repeat → 1 served before 0 (alternation).
- s_a_ready held low 5 cycles → s_a_valid and address stay stable for 6 cycles; transition to WAIT only on the handshake.
- No response with TIMEOUT=8 → owner gets d_valid, d_denied=1, d_data=0 exactly 8 cycles after A handshake; arbiter returns to IDLE.
- Response with s_d_source=1 while requester 0 owns → ignored; the following correct-source response is delivered.
- rst_n asserted during WAIT, then late s_d_valid → no m*_d_valid; grant=00, busy=0.

Source files
------------

// File: rtl/fetch_bus_arbiter.sv
// Two-requester TileLink-UL arbiter: icache (0) and dcache (1) share one core-side port.
// One transaction in flight, grant locked from A issue to D response, round-robin on
// contention, and a response timeout that completes the stalled requester with denied.
module fetch_bus_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  // Requester 0 (icache)
  input  logic                m0_a_valid,
  input  logic [2:0]          m0_a_opcode,
  input  logic [2:0]          m0_a_size,
  input  logic [ADDR_W-1:0]   m0_a_address,
  input  logic [DATA_W/8-1:0] m0_a_mask,
  input  logic [DATA_W-1:0]   m0_a_data,
  output logic                m0_d_valid,
  output logic                m0_d_denied,
  output logic [DATA_W-1:0]   m0_d_data,
  // Requester 1 (dcache)
  input  logic                m1_a_valid,
  input  logic [2:0]          m1_a_opcode,
  input  logic [2:0]          m1_a_size,
  input  logic [ADDR_W-1:0]   m1_a_address,
  input  logic [DATA_W/8-1:0] m1_a_mask,
  input  logic [DATA_W-1:0]   m1_a_data,
  output logic                m1_d_valid,
  output logic                m1_d_denied,
  output logic [DATA_W-1:0]   m1_d_data,
  // Downstream port
  output logic                s_a_valid,
  input  logic                s_a_ready,
  output logic [2:0]          s_a_opcode,
  output logic [2:0]          s_a_size,
  output logic [ADDR_W-1:0]   s_a_address,
  output logic [DATA_W/8-1:0] s_a_mask,
  output logic [DATA_W-1:0]   s_a_data,
  output logic [3:0]          s_a_source,
  input  logic                s_d_valid,
  output logic                s_d_ready,
  input  logic [3:0]          s_d_source,
  input  logic                s_d_denied,
  input  logic [DATA_W-1:0]   s_d_data,
  // Status
  output logic [1:0]          grant,
  output logic                busy
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;       // requester favoured on contention
  logic                owner_q, owner_d;   // index of the granted requester
  logic [1:0]          grant_q, grant_d;
  logic                a_valid_q, a_valid_d;
  logic [2:0]          opcode_q, opcode_d;
  logic [2:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          dv_q, dv_d;         // per-requester response pulse
  logic                denied_q, denied_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                pick;

  // Only bit 0 of the response source identifies the requester.
  logic unused_src;
  assign unused_src = ^s_d_source[3:1];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      grant_q   <= 2'b00;
      a_valid_q <= 1'b0;
      opcode_q  <= '0;
      size_q    <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      dv_q      <= 2'b00;
      denied_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      a_valid_q <= a_valid_d;
      opcode_q  <= opcode_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      dv_q      <= dv_d;
      denied_q  <= denied_d;
      rdata_q   <= rdata_d;
    end
  end

  // Arbitration, issue handshake, response/timeout handling.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    a_valid_d = a_valid_q;
    opcode_d  = opcode_q;
    size_d    = size_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    dv_d      = 2'b00;
    denied_d  = denied_q;
    rdata_d   = rdata_q;
    pick      = (m0_a_valid && m1_a_valid) ? ptr_q : m1_a_valid;

    unique case (state_q)
      StIdle: begin
        if (m0_a_valid || m1_a_valid) begin
          if (m0_a_valid && m1_a_valid) ptr_d = ~ptr_q;
          owner_d   = pick;
          grant_d   = pick ? 2'b10 : 2'b01;
          a_valid_d = 1'b1;
          opcode_d  = pick ? m1_a_opcode  : m0_a_opcode;
          size_d    = pick ? m1_a_size    : m0_a_size;
          addr_d    = pick ? m1_a_address : m0_a_address;
          mask_d    = pick ? m1_a_mask    : m0_a_mask;
          wdata_d   = pick ? m1_a_data    : m0_a_data;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (s_a_ready) begin
          a_valid_d = 1'b0;
          cnt_d     = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A real response beats a timeout landing in the same cycle.
        if (s_d_valid && (s_d_source[0] == owner_q)) begin
          dv_d[owner_q] = 1'b1;
          rdata_d       = s_d_data;
          denied_d      = s_d_denied;
          grant_d       = 2'b00;
          state_d       = StDone;
        end else if (cnt_q == CntLast) begin
          dv_d[owner_q] = 1'b1;
          rdata_d       = '0;
          denied_d      = 1'b1;
          grant_d       = 2'b00;
          state_d       = StDone;
        end
      end
      StDone: begin
        // Bubble lets the requester drop a_valid before re-arbitration.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign s_a_valid   = a_valid_q;
  assign s_a_opcode  = opcode_q;
  assign s_a_size    = size_q;
  assign s_a_address = addr_q;
  assign s_a_mask    = mask_q;
  assign s_a_data    = wdata_q;
  assign s_a_source  = {3'b000, owner_q};
  assign s_d_ready   = 1'b1;
  assign grant       = grant_q;
  assign busy        = (state_q != StIdle);

  assign m0_d_valid  = dv_q[0];
  assign m0_d_denied = dv_q[0] & denied_q;
  assign m0_d_data   = dv_q[0] ? rdata_q : '0;
  assign m1_d_valid  = dv_q[1];
  assign m1_d_denied = dv_q[1] & denied_q;
  assign m1_d_data   = dv_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// Directed self-checking bench for fetch_bus_arbiter (TIMEOUT=8).
module tb_fetch_bus_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m0_a_valid, m1_a_valid;
  logic [2:0]        m0_a_opcode, m1_a_opcode, m0_a_size, m1_a_size;
  logic [ADDR_W-1:0] m0_a_address, m1_a_address;
  logic [7:0]        m0_a_mask, m1_a_mask;
  logic [DATA_W-1:0] m0_a_data, m1_a_data;
  logic              m0_d_valid, m0_d_denied, m1_d_valid, m1_d_denied;
  logic [DATA_W-1:0] m0_d_data, m1_d_data;
  logic              s_a_valid, s_a_ready;
  logic [2:0]        s_a_opcode, s_a_size;
  logic [ADDR_W-1:0] s_a_address;
  logic [7:0]        s_a_mask;
  logic [DATA_W-1:0] s_a_data;
  logic [3:0]        s_a_source;
  logic              s_d_valid, s_d_ready, s_d_denied;
  logic [3:0]        s_d_source;
  logic [DATA_W-1:0] s_d_data;
  logic [1:0]        grant;
  logic              busy;

  int checks = 0;
  int failures = 0;

  fetch_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_a_valid(m0_a_valid), .m0_a_opcode(m0_a_opcode), .m0_a_size(m0_a_size),
    .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
    .m0_d_valid(m0_d_valid), .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data),
    .m1_a_valid(m1_a_valid), .m1_a_opcode(m1_a_opcode), .m1_a_size(m1_a_size),
    .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
    .m1_d_valid(m1_d_valid), .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_size(s_a_size), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
    .s_a_data(s_a_data), .s_a_source(s_a_source),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_source(s_d_source),
    .s_d_denied(s_d_denied), .s_d_data(s_d_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [3:0] src, input logic [63:0] data, input logic den);
    s_d_valid  = 1'b1;
    s_d_source = src;
    s_d_data   = data;
    s_d_denied = den;
  endtask

  task automatic no_resp();
    s_d_valid  = 1'b0;
    s_d_source = 4'h0;
    s_d_data   = '0;
    s_d_denied = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_a_valid = 0; m0_a_opcode = 3'd4; m0_a_size = 3'd3; m0_a_address = '0;
    m0_a_mask = 8'hff; m0_a_data = '0;
    m1_a_valid = 0; m1_a_opcode = 3'd0; m1_a_size = 3'd3; m1_a_address = '0;
    m1_a_mask = 8'h0f; m1_a_data = 64'hdead_beef_0000_0001;
    s_a_ready = 1'b1;
    no_resp();
    #12;
    // Reset state
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_s_a_valid", s_a_valid, 0);
    chk("rst_s_d_ready", s_d_ready, 1);
    chk("rst_m0_d_valid", m0_d_valid, 0);
    chk("rst_m1_d_valid", m1_d_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single icache Get
    m0_a_valid = 1; m0_a_address = 64'h8000_0000;
    tick();
    chk("t1_s_a_valid", s_a_valid, 1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_source", s_a_source, 4'd0);
    chk("t1_addr", s_a_address, 64'h8000_0000);
    chk("t1_opcode", s_a_opcode, 3'd4);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_a_dropped", s_a_valid, 0);
    tick();
    tick();
    respond(4'd0, 64'h1122334455667788, 1'b0);
    tick();
    no_resp();
    chk("t1_m0_dv", m0_d_valid, 1);
    chk("t1_m0_data", m0_d_data, 64'h1122334455667788);
    chk("t1_m0_denied", m0_d_denied, 0);
    chk("t1_m1_dv", m1_d_valid, 0);
    chk("t1_done_busy", busy, 1);
    m0_a_valid = 0;
    tick();
    chk("t1_m0_dv_pulse", m0_d_valid, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_grant", grant, 2'b00);

    // Contention: 0 first, then 1
    m0_a_valid = 1; m0_a_address = 64'h100;
    m1_a_valid = 1; m1_a_address = 64'h200;
    tick();
    chk("t2a_grant", grant, 2'b01);
    chk("t2a_addr", s_a_address, 64'h100);
    tick();
    respond(4'd0, 64'haaaa, 1'b0);
    tick();
    no_resp();
    chk("t2a_m0_dv", m0_d_valid, 1);
    m0_a_valid = 0;
    tick();
    tick();
    chk("t2b_grant", grant, 2'b10);
    chk("t2b_source", s_a_source, 4'd1);
    chk("t2b_addr", s_a_address, 64'h200);
    chk("t2b_opcode", s_a_opcode, 3'd0);
    tick();
    respond(4'd1, 64'hbbbb, 1'b0);
    tick();
    no_resp();
    chk("t2b_m1_dv", m1_d_valid, 1);
    chk("t2b_m1_data", m1_d_data, 64'hbbbb);
    chk("t2b_m0_dv", m0_d_valid, 0);
    m1_a_valid = 0;
    tick();
    // Contention again: 1 first, then 0
    m0_a_valid = 1; m1_a_valid = 1;
    tick();
    chk("t2c_grant", grant, 2'b10);
    tick();
    respond(4'd1, 64'hcccc, 1'b0);
    tick();
    no_resp();
    chk("t2c_m1_dv", m1_d_valid, 1);
    m1_a_valid = 0;
    tick();
    tick();
    chk("t2d_grant", grant, 2'b01);
    tick();
    respond(4'd0, 64'hdddd, 1'b1);
    tick();
    no_resp();
    chk("t2d_m0_dv", m0_d_valid, 1);
    chk("t2d_m0_denied", m0_d_denied, 1);
    m0_a_valid = 0;
    tick();

    // Backpressure, then timeout on the same transaction
    s_a_ready = 0;
    m1_a_valid = 1; m1_a_address = 64'h3000;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", s_a_valid, 1);
      chk("t3_hold_addr", s_a_address, 64'h3000);
      tick();
    end
    s_a_ready = 1;
    chk("t3_last_valid", s_a_valid, 1);
    chk("t3_last_addr", s_a_address, 64'h3000);
    tick();
    chk("t3_handshake", s_a_valid, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t4_no_dv_yet", m1_d_valid, 0);
    end
    tick();
    chk("t4_to_dv", m1_d_valid, 1);
    chk("t4_to_denied", m1_d_denied, 1);
    chk("t4_to_data", m1_d_data, 64'h0);
    chk("t4_to_m0", m0_d_valid, 0);
    m1_a_valid = 0;
    tick();
    chk("t4_idle", busy, 0);
    chk("t4_grant", grant, 2'b00);

    // Wrong-source response ignored, correct one delivered
    m0_a_valid = 1;
    tick();
    chk("t5_grant", grant, 2'b01);
    tick();
    respond(4'd1, 64'h5555, 1'b0);
    tick();
    chk("t5_wrong_m0", m0_d_valid, 0);
    chk("t5_wrong_m1", m1_d_valid, 0);
    chk("t5_busy", busy, 1);
    respond(4'd0, 64'h6666, 1'b0);
    tick();
    no_resp();
    chk("t5_m0_dv", m0_d_valid, 1);
    chk("t5_m0_data", m0_d_data, 64'h6666);
    m0_a_valid = 0;
    tick();

    // Response arriving in the timeout cycle wins
    m0_a_valid = 1;
    tick();
    tick();
    for (int i = 1; i < 8; i++) tick();
    respond(4'd0, 64'h7777, 1'b0);
    tick();
    no_resp();
    chk("t6_dv", m0_d_valid, 1);
    chk("t6_denied", m0_d_denied, 0);
    chk("t6_data", m0_d_data, 64'h7777);
    m0_a_valid = 0;
    tick();

    // Reset during WAIT, then late response
    m1_a_valid = 1;
    tick();
    tick();
    tick();
    chk("t7_busy_pre", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("t7_rst_grant", grant, 2'b00);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_s_a_valid", s_a_valid, 0);
    tick();
    rst_n = 1;
    m1_a_valid = 0;
    respond(4'd1, 64'h8888, 1'b0);
    tick();
    no_resp();
    chk("t7_late_m1", m1_d_valid, 0);
    chk("t7_late_m0", m0_d_valid, 0);
    chk("t7_late_busy", busy, 0);
    chk("t7_late_grant", grant, 2'b00);
    tick();
    chk("t7_after_m1", m1_d_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
